vga_display_engine: RTL

VGA_DISPLAY_ENGINE -- requirements
Module: vga_display_engine

---
 rtl/vga_display_engine.sv | 129 ++++++++++++
 1 files changed

// File: rtl/vga_display_engine.sv
// vga_display_engine: VGA timing generator with a latency-matched BGR233 colour output path.
// Ports:
//   iVGA_CLK, iRST_n      pixel clock and asynchronous active-low reset
//   iEN                   timing run enable (counters hold while low)
//   bgr_data_8            pixel colour {blue[2:0], green[2:0], red[1:0]}, valid PIPE_LAT cycles after pixelX/pixelY
//   pixelX, pixelY        horizontal / vertical counters
//   oHS, oVS, oBLANK_n    syncs and visible flag, PIPE_LAT+1 cycles after the counter state
//   oVGA_B/G/R            expanded colour, forced to 0 outside the visible area
//   startOfFrame          one-cycle pulse registered from hcnt==0, vcnt==V_ACTIVE
//   oLineStart            one-cycle pulse registered from hcnt==0
//   oFrameCount           completed-frame counter
// H_TOTAL and V_TOTAL must not exceed 2048.
module vga_display_engine #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_LAT = 2,
  parameter int COLOR_W  = 4
) (
  input  logic               iVGA_CLK,
  input  logic               iRST_n,
  input  logic               iEN,
  input  logic [7:0]         bgr_data_8,
  output logic [10:0]        pixelX,
  output logic [10:0]        pixelY,
  output logic               oHS,
  output logic               oVS,
  output logic               oBLANK_n,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic               startOfFrame,
  output logic               oLineStart,
  output logic [15:0]        oFrameCount
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [15:0] frame_q, frame_d;
  logic h_wrap, v_wrap;
  // Each pipe stage holds active-high {visible, hsync, vsync}; polarity is applied at the output register.
  logic [2:0] raw;
  logic [2:0] pipe_q [PIPE_LAT];
  logic [2:0] pipe_d [PIPE_LAT];
  logic vis_q, vis_d, hs_q, hs_d, vs_q, vs_d, sof_q, sof_d, ls_q, ls_d;
  logic [COLOR_W-1:0] b_q, b_d, g_q, g_d, r_q, r_d;
  // Repeating each field and keeping the top bits gives MSB-repeating replication for any COLOR_W up to 8.
  logic [8:0] b_rep, g_rep;
  logic [7:0] r_rep;
  always_comb begin
    h_wrap  = hcnt_q == H_LAST;
    v_wrap  = vcnt_q == V_LAST;
    hcnt_d  = !iEN ? hcnt_q : h_wrap ? '0 : hcnt_q + 11'd1;
    vcnt_d  = !(iEN && h_wrap) ? vcnt_q : v_wrap ? '0 : vcnt_q + 11'd1;
    frame_d = (iEN && h_wrap && v_wrap) ? frame_q + 16'd1 : frame_q;
    // Gating with iEN drains the pipe to inactive values while timing is paused.
    raw = {3{iEN}} & {hcnt_q < H_VIS && vcnt_q < V_VIS,
                      hcnt_q >= HS_BEG && hcnt_q < HS_END,
                      vcnt_q >= VS_BEG && vcnt_q < VS_END};
    pipe_d[0] = raw;
    for (int i = 1; i < PIPE_LAT; i++) pipe_d[i] = pipe_q[i-1];
    vis_d = pipe_q[PIPE_LAT-1][2];
    hs_d  = pipe_q[PIPE_LAT-1][1] ? HS_POL : ~HS_POL;
    vs_d  = pipe_q[PIPE_LAT-1][0] ? VS_POL : ~VS_POL;
    b_rep = {3{bgr_data_8[7:5]}};
    g_rep = {3{bgr_data_8[4:2]}};
    r_rep = {4{bgr_data_8[1:0]}};
    b_d   = vis_d ? b_rep[8 -: COLOR_W] : '0;
    g_d   = vis_d ? g_rep[8 -: COLOR_W] : '0;
    r_d   = vis_d ? r_rep[7 -: COLOR_W] : '0;
    ls_d  = iEN && hcnt_q == '0;
    sof_d = ls_d && vcnt_q == V_VIS;
  end
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      frame_q <= '0;
      pipe_q  <= '{default: '0};
      vis_q   <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      b_q     <= '0;
      g_q     <= '0;
      r_q     <= '0;
      sof_q   <= 1'b0;
      ls_q    <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      frame_q <= frame_d;
      pipe_q  <= pipe_d;
      vis_q   <= vis_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      b_q     <= b_d;
      g_q     <= g_d;
      r_q     <= r_d;
      sof_q   <= sof_d;
      ls_q    <= ls_d;
    end
  end
  assign pixelX       = hcnt_q;
  assign pixelY       = vcnt_q;
  assign oHS          = hs_q;
  assign oVS          = vs_q;
  assign oBLANK_n     = vis_q;
  assign oVGA_B       = b_q;
  assign oVGA_G       = g_q;
  assign oVGA_R       = r_q;
  assign startOfFrame = sof_q;
  assign oLineStart   = ls_q;
  assign oFrameCount  = frame_q;
endmodule
